tree_walker: RTL and testbench

- Traversal engine that sits directly upstream of Slave_Memory and acts as its sole master.
- Walks the 32-entry binary tree from root node 0, following a caller-supplied direction bit string.
- Returns the value held at the terminal node; for write operations, it rewrites that node's value field in the same transaction.

---
 rtl/tree_pkg.sv | 30 +++
 rtl/tree_walker_if.sv | 25 ++
 rtl/tree_walker_node_decode.sv | 17 +
 rtl/tree_walker.sv | 148 ++++++++++++++
 tb/tb_tree_walker.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tree_pkg.sv
// Shared definitions for the binary-tree walker, its node memory and the
// initial-tree data.
//   - Address/node widths and the null/root address.
//   - Bit-slice positions of the left child, right child and value fields.
//   - Walker FSM state encoding.
package tree_pkg;

  localparam int ADDR_W = 5;
  localparam int NODE_W = 12;
  localparam int VAL_W  = 2;

  // Address 0 doubles as "no child" because the root is never a child.
  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;
  localparam logic [ADDR_W-1:0] ROOT_ADDR = '0;

  localparam int LEFT_HI  = 11;
  localparam int LEFT_LO  = 7;
  localparam int RIGHT_HI = 6;
  localparam int RIGHT_LO = 2;
  localparam int VAL_HI   = 1;
  localparam int VAL_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/tree_walker_if.sv
// Node-memory bus between the tree walker (master) and Slave_Memory (slave).
//   read_addr  : node address to read
//   read_node  : node word, combinational in read_addr
//   write_addr : node address to write
//   write_node : node word to write
//   write      : write strobe
interface tree_walker_if;
  import tree_pkg::*;

  logic [ADDR_W-1:0] read_addr;
  logic [NODE_W-1:0] read_node;
  logic [ADDR_W-1:0] write_addr;
  logic [NODE_W-1:0] write_node;
  logic              write;

  modport master (
    output read_addr, write_addr, write_node, write,
    input  read_node
  );

  modport slave (
    input  read_addr, write_addr, write_node, write,
    output read_node
  );
endinterface

// File: rtl/tree_walker_node_decode.sv
// Splits a tree node word into its fields (purely combinational).
//   node_i  : node word
//   left_o  : left child address (0 = null)
//   right_o : right child address (0 = null)
//   value_o : value field
module node_decode
  import tree_pkg::*;
(
  input  logic [NODE_W-1:0] node_i,
  output logic [ADDR_W-1:0] left_o,
  output logic [ADDR_W-1:0] right_o,
  output logic [VAL_W-1:0]  value_o
);
  assign left_o  = node_i[LEFT_HI:LEFT_LO];
  assign right_o = node_i[RIGHT_HI:RIGHT_LO];
  assign value_o = node_i[VAL_HI:VAL_LO];
endmodule

// File: rtl/tree_walker.sv
// Walks the node tree from the root following a direction bit string,
// reports the terminal node and optionally rewrites its value field.
//   clk, reset      : clock, asynchronous active-low reset
//   start/op/path/depth/wdata : request (sampled only in IDLE)
//   busy, done      : walk in progress / one-cycle completion pulse
//   result_*        : terminal value (pre-write), address, hops, null-stop
//   mem             : master port to the node memory
module tree_walker
  import tree_pkg::*;
#(
  parameter int PATH_W  = 15,
  parameter int DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic [PATH_W-1:0]  path,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [VAL_W-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [VAL_W-1:0]   result_value,
  output logic [ADDR_W-1:0]  result_addr,
  output logic [DEPTH_W-1:0] result_hops,
  output logic               result_null,
  tree_walker_if.master      mem
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(PATH_W);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [DEPTH_W-1:0] hops_q, hops_d;
  logic               op_q, op_d;
  logic [PATH_W-1:0]  path_q, path_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [VAL_W-1:0]   wdata_q, wdata_d;
  logic [VAL_W-1:0]   result_value_q, result_value_d;
  logic [ADDR_W-1:0]  result_addr_q, result_addr_d;
  logic [DEPTH_W-1:0] result_hops_q, result_hops_d;
  logic               result_null_q, result_null_d;

  logic [ADDR_W-1:0]  node_left, node_right, child;
  logic [VAL_W-1:0]   node_value;
  logic               dir, at_depth;
  logic [DEPTH_W-1:0] depth_clamped;

  node_decode u_decode (
    .node_i  (mem.read_node),
    .left_o  (node_left),
    .right_o (node_right),
    .value_o (node_value)
  );

  assign depth_clamped = (depth > DEPTH_MAX) ? DEPTH_MAX : depth;
  // hops can only reach PATH_W when it also equals depth, where the direction
  // bit is unused; guard the index anyway.
  assign dir      = (int'(hops_q) < PATH_W) ? path_q[hops_q] : 1'b0;
  assign child    = dir ? node_right : node_left;
  assign at_depth = (hops_q == depth_q);

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    hops_d         = hops_q;
    op_d           = op_q;
    path_d         = path_q;
    depth_d        = depth_q;
    wdata_d        = wdata_q;
    result_value_d = result_value_q;
    result_addr_d  = result_addr_q;
    result_hops_d  = result_hops_q;
    result_null_d  = result_null_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = op;
          path_d     = path;
          depth_d    = depth_clamped;
          wdata_d    = wdata;
          cur_addr_d = ROOT_ADDR;
          hops_d     = '0;
          state_d    = WALK;
        end
      end
      WALK: begin
        // Depth limit wins over a null child, so depth 0 stops at the root.
        if (at_depth || child == NULL_ADDR) begin
          result_value_d = node_value;
          result_addr_d  = cur_addr_q;
          result_hops_d  = hops_q;
          result_null_d  = !at_depth;
          state_d        = op_q ? WRITE : DONE;
        end else begin
          cur_addr_d = child;
          hops_d     = hops_q + DEPTH_W'(1);
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cur_addr_q     <= '0;
      hops_q         <= '0;
      op_q           <= 1'b0;
      path_q         <= '0;
      depth_q        <= '0;
      wdata_q        <= '0;
      result_value_q <= '0;
      result_addr_q  <= '0;
      result_hops_q  <= '0;
      result_null_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      hops_q         <= hops_d;
      op_q           <= op_d;
      path_q         <= path_d;
      depth_q        <= depth_d;
      wdata_q        <= wdata_d;
      result_value_q <= result_value_d;
      result_addr_q  <= result_addr_d;
      result_hops_q  <= result_hops_d;
      result_null_q  <= result_null_d;
    end
  end

  assign busy         = (state_q == WALK) || (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign result_value = result_value_q;
  assign result_addr  = result_addr_q;
  assign result_hops  = result_hops_q;
  assign result_null  = result_null_q;

  // cur_addr still points at the terminal node during WRITE, so read_node
  // supplies the child fields that are written back unchanged.
  assign mem.read_addr  = cur_addr_q;
  assign mem.write      = (state_q == WRITE);
  assign mem.write_addr = mem.write ? cur_addr_q : '0;
  assign mem.write_node = mem.write ? {node_left, node_right, wdata_q} : '0;

endmodule

// File: tb/tb_tree_walker.sv
module tb_tree_walker;
  import tree_pkg::*;

  typedef struct {
    logic [1:0]  value;
    logic [4:0]  addr;
    logic [3:0]  hops;
    logic        nul;
    logic        is_write;
    logic [11:0] wnode;
    int          write_edge;
    int          done_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [14:0] path = '0;
  logic [3:0]  depth = '0;
  logic [1:0]  wdata = '0;
  logic        busy, done, result_null;
  logic [1:0]  result_value;
  logic [4:0]  result_addr;
  logic [3:0]  result_hops;
  logic        preload = 1'b1;

  logic [11:0] mem_q [32];
  logic [11:0] ref_mem [32];
  logic [4:0]  wr_left, wr_right;
  logic [1:0]  wr_value;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_writes = 0;
  int   exp_writes = 0;
  int   cycle_cnt = 0;

  tree_walker_if bus ();

  tree_walker dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .path         (path),
    .depth        (depth),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .result_value (result_value),
    .result_addr  (result_addr),
    .result_hops  (result_hops),
    .result_null  (result_null),
    .mem          (bus)
  );

  node_decode wr_dec (
    .node_i  (bus.write_node),
    .left_o  (wr_left),
    .right_o (wr_right),
    .value_o (wr_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [11:0] init_node(input int i);
    case (i)
      0: init_node = 12'h088;
      1: init_node = 12'h181;
      2: init_node = 12'h002;
      3: init_node = 12'h003;
      default: init_node = 12'h000;
    endcase
  endfunction

  // Node memory model: combinational read, write on the clock edge.
  assign bus.read_node = mem_q[bus.read_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= init_node(i);
    end else if (bus.write) begin
      mem_q[bus.write_addr] <= bus.write_node;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference walk over the bench's own copy of the tree.
  task automatic model_push(input logic op_v, input logic [14:0] p, input logic [3:0] d,
                            input logic [1:0] wd, input int acc);
    exp_t e;
    logic [4:0]  a;
    logic [3:0]  h;
    logic [11:0] n;
    logic [4:0]  ch;
    a = 5'd0;
    h = 4'd0;
    n = ref_mem[0];
    e.nul = 1'b0;
    for (int k = 0; k < 17; k++) begin
      n = ref_mem[a];
      if (h == d) begin
        e.nul = 1'b0;
        break;
      end
      ch = p[h] ? n[6:2] : n[11:7];
      if (ch == 5'd0) begin
        e.nul = 1'b1;
        break;
      end
      a = ch;
      h = h + 4'd1;
    end
    e.value      = n[1:0];
    e.addr       = a;
    e.hops       = h;
    e.is_write   = op_v;
    e.wnode      = {n[11:2], wd};
    e.write_edge = acc + int'(h) + 1;
    e.done_edge  = e.write_edge + (op_v ? 1 : 0);
    if (op_v) begin
      ref_mem[a] = e.wnode;
      exp_writes++;
    end
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.write) begin
        n_writes++;
        if (sb_q.size() == 0 || !sb_q[0].is_write) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          chk("write_edge", cycle_cnt, sb_q[0].write_edge);
          chk("write_addr", 32'(bus.write_addr), 32'(sb_q[0].addr));
          chk("write_node", 32'(bus.write_node), 32'(sb_q[0].wnode));
          chk("write_left", 32'(wr_left), 32'(sb_q[0].wnode[11:7]));
          chk("write_right", 32'(wr_right), 32'(sb_q[0].wnode[6:2]));
          chk("write_value", 32'(wr_value), 32'(sb_q[0].wnode[1:0]));
        end
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("done_edge", cycle_cnt, mon_e.done_edge);
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("result_value", 32'(result_value), 32'(mon_e.value));
          chk("result_addr", 32'(result_addr), 32'(mon_e.addr));
          chk("result_hops", 32'(result_hops), 32'(mon_e.hops));
          chk("result_null", 32'(result_null), 32'(mon_e.nul));
          $display("txn %s addr=%0d value=%0d hops=%0d null=%0d at edge %0d",
                   mon_e.is_write ? "write" : "read ", result_addr, result_value,
                   result_hops, result_null, cycle_cnt);
        end
      end
    end
  end

  task automatic pulse_start(input logic op_v, input logic [14:0] p, input logic [3:0] d,
                             input logic [1:0] wd);
    @(negedge clk);
    op = op_v;
    path = p;
    depth = d;
    wdata = wd;
    start = 1'b1;
    model_push(op_v, p, d, wd, cycle_cnt + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 80) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic run_txn(input logic op_v, input logic [14:0] p, input logic [3:0] d,
                         input logic [1:0] wd);
    pulse_start(op_v, p, d, wd);
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_write"}, 32'(bus.write), 32'd0);
    chk({tag, "_read_addr"}, 32'(bus.read_addr), 32'd0);
    chk({tag, "_write_addr"}, 32'(bus.write_addr), 32'd0);
    chk({tag, "_write_node"}, 32'(bus.write_node), 32'd0);
    chk({tag, "_result"}, {19'd0, result_value, result_addr, result_hops, result_null}, 32'd0);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_node(i);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    preload = 1'b0;
    reset = 1'b1;

    // Basic reads and the write/read-back pair from the test plan.
    run_txn(1'b0, 15'h0000, 4'd2, 2'd0);
    run_txn(1'b0, 15'h0001, 4'd3, 2'd0);
    run_txn(1'b1, 15'h0000, 4'd1, 2'd2);
    run_txn(1'b0, 15'h0000, 4'd1, 2'd0);
    run_txn(1'b0, 15'h7fff, 4'd0, 2'd0);

    // Start re-pulsed (as a write) while busy must be ignored.
    pulse_start(1'b0, 15'h0000, 4'd2, 2'd0);
    @(negedge clk);
    op = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Start held through DONE: ignored there, accepted the cycle after.
    @(negedge clk);
    op = 1'b0;
    path = '0;
    depth = 4'd0;
    start = 1'b1;
    acc = cycle_cnt + 1;
    model_push(1'b0, 15'h0000, 4'd0, 2'd0, acc);
    model_push(1'b0, 15'h0000, 4'd0, 2'd0, acc + 3);
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Leave non-zero results, then reset during the WALK of a depth-3 read.
    run_txn(1'b0, 15'h0000, 4'd2, 2'd0);
    pulse_start(1'b0, 15'h0000, 4'd3, 2'd0);
    @(negedge clk);
    chk("busy_mid_walk", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_txn(1'b0, 15'h0000, 4'd2, 2'd0);

    // A few random operations against the running model.
    for (int t = 0; t < 8; t++) begin
      run_txn(1'($urandom_range(0, 1)), 15'($urandom), 4'($urandom_range(0, 6)),
              2'($urandom_range(0, 3)));
    end
    repeat (4) @(negedge clk);

    chk("write_total", n_writes, exp_writes);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
